// File: rtl/mix_columns.sv
// AES MixColumns / InvMixColumns round stage with last-round bypass.
// Iterative by default; define MIXCOL_PARALLEL_EN for the one-cycle build.

module mix_columns_col (
    input  logic [31:0] i_col,
    input  logic        i_enc,
    input  logic        i_bypass,
    output logic [31:0] o_col
);

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] w_a  [4];
    logic [7:0] w_x2 [4];
    logic [7:0] w_x4 [4];
    logic [7:0] w_x8 [4];
    logic [7:0] w_m3 [4];
    logic [7:0] w_m9 [4];
    logic [7:0] w_mb [4];
    logic [7:0] w_md [4];
    logic [7:0] w_me [4];
    logic [7:0] w_b  [4];

    assign w_a[0] = i_col[31:24];
    assign w_a[1] = i_col[23:16];
    assign w_a[2] = i_col[15:8];
    assign w_a[3] = i_col[7:0];

    // Every row multiple comes from one xtime chain per byte
    for (genvar g = 0; g < 4; g++) begin : g_mul
        assign w_x2[g] = xt(w_a[g]);
        assign w_x4[g] = xt(w_x2[g]);
        assign w_x8[g] = xt(w_x4[g]);
        assign w_m3[g] = w_x2[g] ^ w_a[g];
        assign w_m9[g] = w_x8[g] ^ w_a[g];
        assign w_mb[g] = w_x8[g] ^ w_x2[g] ^ w_a[g];
        assign w_md[g] = w_x8[g] ^ w_x4[g] ^ w_a[g];
        assign w_me[g] = w_x8[g] ^ w_x4[g] ^ w_x2[g];
    end

    for (genvar r = 0; r < 4; r++) begin : g_row
        localparam logic [1:0] R0 = 2'(r);
        localparam logic [1:0] R1 = 2'(r + 1);
        localparam logic [1:0] R2 = 2'(r + 2);
        localparam logic [1:0] R3 = 2'(r + 3);

        assign w_b[r] = i_enc
            ? (w_x2[R0] ^ w_m3[R1] ^ w_a[R2] ^ w_a[R3])
            : (w_me[R0] ^ w_mb[R1] ^ w_md[R2] ^ w_m9[R3]);
    end

    assign o_col = i_bypass ? i_col : {w_b[0], w_b[1], w_b[2], w_b[3]};

endmodule

module mix_columns (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] in,
    input  logic         ready,
    input  logic         encrypt,
    input  logic         last_round,
    output logic [127:0] out,
    output logic         done,
    output logic         busy
);

    logic [127:0] r_in;
    logic         r_enc;
    logic         r_last;
    logic [127:0] r_out;
    logic         r_done;

    assign out  = r_out;
    assign done = r_done;

`ifdef MIXCOL_PARALLEL_EN

    logic         r_v;
    logic [127:0] w_res;

    for (genvar c = 0; c < 4; c++) begin : g_col
        mix_columns_col u_col (
            .i_col    (r_in[127-32*c -: 32]),
            .i_enc    (r_enc),
            .i_bypass (r_last),
            .o_col    (w_res[127-32*c -: 32])
        );
    end

    assign busy = 1'b0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_v    <= 1'b0;
            r_in   <= '0;
            r_enc  <= 1'b0;
            r_last <= 1'b0;
            r_out  <= '0;
            r_done <= 1'b0;
        end else begin
            r_v    <= ready;
            r_done <= r_v;
            if (ready) begin
                r_in   <= in;
                r_enc  <= encrypt;
                r_last <= last_round;
            end
            if (r_v) begin
                r_out <= w_res;
            end
        end
    end

`else

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t      r_state;
    logic [1:0]  r_col;
    logic        r_busy;
    logic [31:0] w_col_in;
    logic [31:0] w_col_out;

    assign busy = r_busy;

    always_comb begin
        w_col_in = r_in[127:96];
        unique case (r_col)
            2'd0: w_col_in = r_in[127:96];
            2'd1: w_col_in = r_in[95:64];
            2'd2: w_col_in = r_in[63:32];
            2'd3: w_col_in = r_in[31:0];
        endcase
    end

    mix_columns_col u_col (
        .i_col    (w_col_in),
        .i_enc    (r_enc),
        .i_bypass (r_last),
        .o_col    (w_col_out)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_col   <= 2'd0;
            r_in    <= '0;
            r_enc   <= 1'b0;
            r_last  <= 1'b0;
            r_out   <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (ready) begin
                        r_in    <= in;
                        r_enc   <= encrypt;
                        r_last  <= last_round;
                        r_col   <= 2'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    unique case (r_col)
                        2'd0: r_out[127:96] <= w_col_out;
                        2'd1: r_out[95:64]  <= w_col_out;
                        2'd2: r_out[63:32]  <= w_col_out;
                        2'd3: r_out[31:0]   <= w_col_out;
                    endcase
                    r_col <= r_col + 2'd1;
                    // ready is ignored here, even on the final column
                    if (r_col == 2'd3) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_mix_columns.sv
// Scoreboard bench for mix_columns: directed AES vectors, ready hold,
// mid-block reset and random forward/inverse round trips.

module tb_mix_columns;

`ifdef MIXCOL_PARALLEL_EN
    localparam int LAT   = 1;
    localparam int BUSYX = 0;
    localparam int HOLD  = 10;
`else
    localparam int LAT   = 4;
    localparam int BUSYX = 1;
    localparam int HOLD  = 2;
`endif

    localparam logic [127:0] V1  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V1M = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V3  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] V3M = 128'h046681e5_e0cb199a_48f8d37a_2806264c;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [127:0] in_d = '0;
    logic         ready = 1'b0;
    logic         encrypt = 1'b0;
    logic         last_round = 1'b0;
    logic [127:0] out;
    logic         done;
    logic         busy;

    mix_columns dut (
        .clk        (clk),
        .reset      (reset),
        .in         (in_d),
        .ready      (ready),
        .encrypt    (encrypt),
        .last_round (last_round),
        .out        (out),
        .done       (done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;
    int n_done = 0;

    logic [127:0] q_exp [$];
    int           q_cyc [$];
    logic [127:0] m_exp;
    int           m_cyc;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s,
                                           input logic e, input logic l);
        logic [7:0]   ce [4];
        logic [7:0]   cd [4];
        logic [7:0]   acc;
        logic [127:0] res;
        ce[0] = 8'h02; ce[1] = 8'h03; ce[2] = 8'h01; ce[3] = 8'h01;
        cd[0] = 8'h0e; cd[1] = 8'h0b; cd[2] = 8'h0d; cd[3] = 8'h09;
        res = '0;
        if (l) return s;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gmul(s[127-32*c-8*j -: 8],
                                     e ? ce[(j-r+4)%4] : cd[(j-r+4)%4]);
                end
                res[127-32*c-8*r -: 8] = acc;
            end
        end
        return res;
    endfunction

    always @(negedge clk) begin
        if (reset && done) begin
            n_done++;
            if (q_exp.size() == 0) begin
                check("spurious_done", {127'b0, done}, 128'h0);
            end else begin
                m_exp = q_exp.pop_front();
                m_cyc = q_cyc.pop_front();
                check("out", out, m_exp);
                check("latency", 128'(cyc - m_cyc), 128'(LAT + 1));
            end
        end
    end

    // Holds ready high until the DUT is idle, then returns after the accepting edge
    task automatic send(input logic [127:0] d, input logic e, input logic l,
                        input logic [127:0] exp);
        int n;
        n = 0;
        in_d = d;
        encrypt = e;
        last_round = l;
        ready = 1'b1;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            check("send_timeout", {127'b0, busy}, 128'h0);
            ready = 1'b0;
            return;
        end
        q_exp.push_back(exp);
        q_cyc.push_back(cyc);
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q_exp.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain", 128'(q_exp.size()), 128'h0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int acc;
        int d0;
        logic [127:0] x;
        logic [127:0] y;
        logic l;

        repeat (3) @(negedge clk);
        check("rst_out", out, 128'h0);
        check("rst_done", {127'b0, done}, 128'h0);
        check("rst_busy", {127'b0, busy}, 128'h0);
        reset = 1'b1;
        @(negedge clk);

        send(V1, 1'b1, 1'b0, V1M);
        ready = 1'b0;
        check("busy_run", {127'b0, busy}, 128'(BUSYX));
        drain();

        send(V1M, 1'b0, 1'b0, V1);
        ready = 1'b0;
        drain();

        send(V3, 1'b1, 1'b1, V3);
        ready = 1'b0;
        drain();

        acc = 0;
        d0 = n_done;
        for (int i = 0; i < 10; i++) begin
            in_d = V3;
            encrypt = 1'b1;
            last_round = 1'b0;
            ready = 1'b1;
            if (!busy) begin
                q_exp.push_back(V3M);
                q_cyc.push_back(cyc);
                acc++;
            end
            @(negedge clk);
        end
        ready = 1'b0;
        drain();
        check("hold_accepts", 128'(acc), 128'(HOLD));
        check("hold_dones", 128'(n_done - d0), 128'(HOLD));

        send(V1, 1'b1, 1'b0, V1M);
        ready = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b0;
        q_exp.delete();
        q_cyc.delete();
        @(negedge clk);
        check("midrst_out", out, 128'h0);
        check("midrst_busy", {127'b0, busy}, 128'h0);
        check("midrst_done", {127'b0, done}, 128'h0);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        send(V1M, 1'b0, 1'b0, V1);
        ready = 1'b0;
        drain();

        for (int i = 0; i < 500; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            l = ($urandom_range(0, 7) == 0);
            y = model(x, 1'b1, l);
            send(x, 1'b1, l, y);
            send(y, 1'b0, l, x);
        end
        ready = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
